// File: rtl/tx_seq_pkg.sv
// Shared definitions for the DAC TX burst sequencer: FSM states, TX config
// word field positions and the field pack helper.
package tx_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int DIV_LSB   = 0;
    localparam int REP_LSB   = 8;
    localparam int ORDER_LSB = 11;
    localparam int SRST_BIT  = 19;

    function automatic logic [31:0] pack_tx_cfg(
        input logic       srst,
        input logic [7:0] div,
        input logic [2:0] rep,
        input logic [7:0] order
    );
        logic [31:0] word;
        word                   = '0;
        word[DIV_LSB +: 8]     = div;
        word[REP_LSB +: 3]     = rep;
        word[ORDER_LSB +: 8]   = order;
        word[SRST_BIT]         = srst;
        return word;
    endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that parks at zero; the zero flag times the
// reset, settle and gap phases of the burst sequencer.
module seq_down_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/tx_burst_sequencer.sv
// Burst sequencer for the LFSR-modulated DAC TX path: latches a burst setup,
// then walks reset, settle, run and gap phases for each burst of the run.
module tx_burst_sequencer
    import tx_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_WIDTH     = 16,
    parameter int GAP_WIDTH     = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [7:0]           cfg_div_i,
    input  logic [2:0]           cfg_rep_i,
    input  logic [7:0]           cfg_order_i,
    input  logic [CNT_WIDTH-1:0] burst_cnt_i,
    input  logic [GAP_WIDTH-1:0] gap_len_i,
    input  logic                 tx_flag_i,
    output logic [31:0]          tx_cfg_o,
    output logic                 dac_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] burst_idx_o
);

    localparam int PHASE_WIDTH = $clog2(RST_CYCLES + SETTLE_CYCLES + 1);
    localparam int TMR_WIDTH   = (GAP_WIDTH > PHASE_WIDTH) ? GAP_WIDTH : PHASE_WIDTH;
    localparam logic [TMR_WIDTH-1:0] RST_LOAD    = TMR_WIDTH'(RST_CYCLES - 1);
    localparam logic [TMR_WIDTH-1:0] SETTLE_LOAD =
        TMR_WIDTH'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_t                 state_reg;
    state_t                 state_next;
    logic [7:0]             div_reg;
    logic [2:0]             rep_reg;
    logic [7:0]             order_reg;
    logic [CNT_WIDTH-1:0]   burst_cnt_reg;
    logic [GAP_WIDTH-1:0]   gap_len_reg;
    logic [CNT_WIDTH-1:0]   idx_next;
    logic                   flag_q;
    logic                   flag_edge;
    logic                   last_burst;
    logic                   latch_cfg;
    logic                   tmr_load;
    logic [TMR_WIDTH-1:0]   tmr_load_val;
    logic                   tmr_zero;
    logic                   srst;

    seq_down_counter #(
        .WIDTH (TMR_WIDTH)
    ) u_phase_tmr (
        .clk      (aclk),
        .rst_n    (aresetn),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .zero     (tmr_zero)
    );

    assign flag_edge  = tx_flag_i & ~flag_q;
    assign last_burst = (burst_cnt_reg != '0) && (burst_idx_o == burst_cnt_reg - 1'b1);

    always_comb begin
        state_next   = state_reg;
        idx_next     = burst_idx_o;
        latch_cfg    = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        case (state_reg)
            ST_IDLE: begin
                // busy_o lags the state by a cycle; a start seen while it is
                // still high belongs to the run that just ended
                if (start_i && !busy_o) begin
                    state_next   = ST_RST;
                    idx_next     = '0;
                    latch_cfg    = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = RST_LOAD;
                end
            end
            ST_RST: begin
                if (tmr_zero) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_next = ST_RUN;
                    end else begin
                        state_next   = ST_SETTLE;
                        tmr_load     = 1'b1;
                        tmr_load_val = SETTLE_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flag_edge) begin
                    if (last_burst) begin
                        state_next = ST_DONE;
                    end else if (gap_len_reg == '0) begin
                        state_next   = ST_RST;
                        idx_next     = burst_idx_o + 1'b1;
                        tmr_load     = 1'b1;
                        tmr_load_val = RST_LOAD;
                    end else begin
                        state_next   = ST_GAP;
                        tmr_load     = 1'b1;
                        tmr_load_val = TMR_WIDTH'(gap_len_reg - 1'b1);
                    end
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    state_next   = ST_RST;
                    idx_next     = burst_idx_o + 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = RST_LOAD;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (abort_i) begin
            state_next = ST_IDLE;
            idx_next   = burst_idx_o;
            latch_cfg  = 1'b0;
            tmr_load   = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg     <= ST_IDLE;
            flag_q        <= 1'b0;
            burst_idx_o   <= '0;
            div_reg       <= '0;
            rep_reg       <= '0;
            order_reg     <= '0;
            burst_cnt_reg <= '0;
            gap_len_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            flag_q      <= tx_flag_i;
            burst_idx_o <= idx_next;
            if (latch_cfg) begin
                div_reg       <= cfg_div_i;
                rep_reg       <= cfg_rep_i;
                order_reg     <= cfg_order_i;
                burst_cnt_reg <= burst_cnt_i;
                gap_len_reg   <= gap_len_i;
            end
        end
    end

    // The LFSR is held in reset everywhere except settle and run
    assign srst = !((state_reg == ST_SETTLE) || (state_reg == ST_RUN));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tx_cfg_o <= pack_tx_cfg(1'b1, 8'd0, 3'd0, 8'd0);
            dac_en_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            tx_cfg_o <= pack_tx_cfg(srst, div_reg, rep_reg, order_reg);
            dac_en_o <= (state_reg == ST_RUN);
            busy_o   <= (state_reg != ST_IDLE);
            done_o   <= (state_reg == ST_DONE);
        end
    end

endmodule

// File: tb/tb_tx_burst_sequencer.sv
// Randomized bench for tx_burst_sequencer: each run is planned as a list of
// phase segments, expanded into per-cycle expectations and checked every cycle.
module tb_tx_burst_sequencer;

    localparam int RSTC = 4;
    localparam int SETC = 2;
    localparam int CW   = 16;
    localparam int GW   = 32;
    localparam int MAXC = 1024;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [7:0]    cfg_div_i = '0;
    logic [2:0]    cfg_rep_i = '0;
    logic [7:0]    cfg_order_i = '0;
    logic [CW-1:0] burst_cnt_i = '0;
    logic [GW-1:0] gap_len_i = '0;
    logic          tx_flag_i = 1'b0;
    logic [31:0]   tx_cfg_o;
    logic          dac_en_o;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] burst_idx_o;

    int tests = 0;
    int fails = 0;

    always #5 aclk = ~aclk;

    tx_burst_sequencer #(
        .RST_CYCLES    (RSTC),
        .SETTLE_CYCLES (SETC),
        .CNT_WIDTH     (CW),
        .GAP_WIDTH     (GW)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .cfg_div_i   (cfg_div_i),
        .cfg_rep_i   (cfg_rep_i),
        .cfg_order_i (cfg_order_i),
        .burst_cnt_i (burst_cnt_i),
        .gap_len_i   (gap_len_i),
        .tx_flag_i   (tx_flag_i),
        .tx_cfg_o    (tx_cfg_o),
        .dac_en_o    (dac_en_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .burst_idx_o (burst_idx_o)
    );

    // Phase plan: entry k describes what the block is doing after clock edge k;
    // the registered outputs show it one cycle later.
    bit ph_en   [MAXC];
    bit ph_busy [MAXC];
    bit ph_done [MAXC];
    bit ph_srst [MAXC];
    int ph_idx  [MAXC];
    bit st_start[MAXC];
    bit st_abort[MAXC];
    bit st_flag [MAXC];
    int kp;
    int run_len;

    logic [7:0] prev_div = '0, prev_order = '0, cur_div = '0, cur_order = '0;
    logic [2:0] prev_rep = '0, cur_rep = '0;

    logic        en_hist  [MAXC];
    logic        done_hist[MAXC];
    logic [31:0] cfg_hist [MAXC];
    int obs_windows, obs_dones, obs_zmin, obs_zmax, obs_last_idx;

    function automatic logic [31:0] model_cfg(input bit s, input logic [7:0] d,
                                              input logic [2:0] r, input logic [7:0] o);
        return (32'(s) << 19) | (32'(o) << 11) | (32'(r) << 8) | 32'(d);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp, input int c);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %h, want %h", name, c, act, exp);
        end
    endtask

    task automatic emit(input int n, input bit en, input bit busy, input bit done,
                        input bit srst, input int idx);
        for (int i = 0; i < n; i++) begin
            ph_en[kp]   = en;
            ph_busy[kp] = busy;
            ph_done[kp] = done;
            ph_srst[kp] = srst;
            ph_idx[kp]  = idx;
            kp++;
        end
    endtask

    // ab_mode: 0 none, 1 abort inside the last burst's run window,
    // 2 abort in the same cycle as the last burst's flag edge
    task automatic build_run(input int nb, input int gap, input int fixed_len,
                             input int pre_mode, input int ab_mode, input bit strays);
        int r, e, len, h, a, endk, tail;
        bit pre, last;
        for (int i = 0; i < MAXC; i++) begin
            st_start[i] = 0; st_abort[i] = 0; st_flag[i] = 0;
            ph_en[i] = 0; ph_busy[i] = 0; ph_done[i] = 0; ph_srst[i] = 1; ph_idx[i] = 0;
        end
        kp = 0;
        endk = 0;
        st_start[0] = 1;
        for (int b = 0; b < nb; b++) begin
            last = (b == nb - 1);
            emit(RSTC, 0, 1, 0, 1, b);
            emit(SETC, 0, 1, 0, 0, b);
            r   = kp;
            pre = (pre_mode == 2) || (pre_mode == 1 && $urandom_range(0, 2) == 0);
            h   = (pre_mode == 2) ? 3 : int'($urandom_range(0, 3));
            len = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 30));
            if (pre) begin
                if (len < h + 2) len = h + 2;
                for (int c = r - 2; c <= r + h; c++) st_flag[c] = 1;
            end
            if (last && ab_mode == 1 && len < 2) len = 2;
            e = r + len;
            if (last && ab_mode == 1) begin
                a = int'($urandom_range(r + 1, e - 1));
                st_abort[a] = 1;
                emit(a - r, 1, 1, 0, 0, b);
                endk = a;
            end else if (last && ab_mode == 2) begin
                st_flag[e] = 1;
                st_abort[e] = 1;
                emit(len, 1, 1, 0, 0, b);
                endk = e;
            end else if (last) begin
                st_flag[e] = 1;
                emit(len, 1, 1, 0, 0, b);
                emit(1, 0, 1, 1, 1, b);
                endk = kp;
            end else begin
                st_flag[e] = 1;
                emit(len, 1, 1, 0, 0, b);
                emit(gap, 0, 1, 0, 1, b);
            end
        end
        tail = int'($urandom_range(2, 5));
        run_len = endk + tail;
        emit(run_len - endk, 0, 0, 0, 1, nb - 1);
        if (strays) begin
            for (int c = 1; c <= endk + 1; c++)
                if ($urandom_range(0, 7) == 0) st_start[c] = 1;
        end
    endtask

    task automatic exec_run(input logic [7:0] div, input logic [2:0] rep,
                            input logic [7:0] order, input int cnt, input int gap);
        bit e_en, e_busy, e_done, prev_en;
        logic [31:0] e_cfg;
        int zrun;
        cur_div = div; cur_rep = rep; cur_order = order;
        obs_windows = 0; obs_dones = 0; obs_zmin = 1 << 30; obs_zmax = -1;
        prev_en = 0; zrun = 0;
        for (int c = 0; c < run_len; c++) begin
            @(negedge aclk);
            start_i   = st_start[c];
            abort_i   = st_abort[c];
            tx_flag_i = st_flag[c];
            if (c == 0) begin
                cfg_div_i = div; cfg_rep_i = rep; cfg_order_i = order;
                burst_cnt_i = CW'(cnt); gap_len_i = GW'(gap);
            end else begin
                cfg_div_i = 8'($urandom); cfg_rep_i = 3'($urandom); cfg_order_i = 8'($urandom);
                burst_cnt_i = CW'($urandom); gap_len_i = GW'($urandom);
            end
            @(posedge aclk);
            #1;
            if (c == 0) begin
                e_en = 0; e_busy = 0; e_done = 0;
                e_cfg = model_cfg(1'b1, prev_div, prev_rep, prev_order);
            end else begin
                e_en = ph_en[c-1]; e_busy = ph_busy[c-1]; e_done = ph_done[c-1];
                e_cfg = model_cfg(ph_srst[c-1], cur_div, cur_rep, cur_order);
            end
            check("dac_en", 32'(dac_en_o), 32'(e_en), c);
            check("busy", 32'(busy_o), 32'(e_busy), c);
            check("done", 32'(done_o), 32'(e_done), c);
            check("tx_cfg", tx_cfg_o, e_cfg, c);
            check("burst_idx", 32'(burst_idx_o), 32'(ph_idx[c]), c);
            en_hist[c] = dac_en_o; done_hist[c] = done_o; cfg_hist[c] = tx_cfg_o;
            if (done_o === 1'b1) obs_dones++;
            if (dac_en_o === 1'b1 && !prev_en) begin
                if (obs_windows > 0) begin
                    if (zrun < obs_zmin) obs_zmin = zrun;
                    if (zrun > obs_zmax) obs_zmax = zrun;
                end
                obs_windows++;
                zrun = 0;
            end else if (dac_en_o !== 1'b1 && obs_windows > 0) begin
                zrun++;
            end
            prev_en = (dac_en_o === 1'b1);
            obs_last_idx = int'(burst_idx_o);
        end
        prev_div = div; prev_rep = rep; prev_order = order;
    endtask

    initial begin
        int nb, cnt, gap, ab;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tx_cfg", tx_cfg_o, 32'h0008_0000, 0);
        check("rst_dac_en", 32'(dac_en_o), 32'd0, 0);
        check("rst_busy", 32'(busy_o), 32'd0, 0);
        check("rst_done", 32'(done_o), 32'd0, 0);
        check("rst_idx", 32'(burst_idx_o), 32'd0, 0);
        @(negedge aclk);
        aresetn = 1'b1;

        // Single burst, flag edge sampled at cycle 50
        build_run(1, 5, 44, 0, 0, 0);
        exec_run(8'h10, 3'd3, 8'd7, 1, 5);
        check("lit_cfg_in_rst", cfg_hist[1], 32'h0008_3B10, 1);
        check("lit_en_c6", 32'(en_hist[6]), 32'd0, 6);
        check("lit_en_c7", 32'(en_hist[7]), 32'd1, 7);
        check("lit_en_c50", 32'(en_hist[50]), 32'd1, 50);
        check("lit_en_c51", 32'(en_hist[51]), 32'd0, 51);
        check("lit_done_c51", 32'(done_hist[51]), 32'd1, 51);
        check("lit_done_c52", 32'(done_hist[52]), 32'd0, 52);

        // Three bursts, gap of 10
        build_run(3, 10, 0, 0, 0, 0);
        exec_run(8'h21, 3'd5, 8'h40, 3, 10);
        check("lit3_windows", 32'(obs_windows), 32'd3, run_len);
        check("lit3_dones", 32'(obs_dones), 32'd1, run_len);
        check("lit3_gap_min", 32'(obs_zmin), 32'd16, run_len);
        check("lit3_gap_max", 32'(obs_zmax), 32'd16, run_len);
        check("lit3_last_idx", 32'(obs_last_idx), 32'd2, run_len);

        // Continuous mode, aborted inside the fifth burst
        build_run(5, int'($urandom_range(0, 8)), 0, 0, 1, 1);
        exec_run(8'h05, 3'd1, 8'h11, 0, 0);
        check("litc_windows", 32'(obs_windows), 32'd5, run_len);
        check("litc_dones", 32'(obs_dones), 32'd0, run_len);
        check("litc_last_idx", 32'(obs_last_idx), 32'd4, run_len);

        // Flag already high when the run window opens
        build_run(1, 0, 14, 2, 0, 0);
        exec_run(8'h77, 3'd2, 8'h09, 1, 0);
        check("litp_en_c10", 32'(en_hist[10]), 32'd1, 10);
        check("litp_en_c20", 32'(en_hist[20]), 32'd1, 20);
        check("litp_done_c21", 32'(done_hist[21]), 32'd1, 21);
        check("litp_dones", 32'(obs_dones), 32'd1, run_len);

        // Abort coincident with the final flag edge, stray starts mid-run
        build_run(2, 3, 0, 0, 2, 1);
        exec_run(8'h3C, 3'd6, 8'hA5, 2, 3);
        check("lita_dones", 32'(obs_dones), 32'd0, run_len);
        check("lita_last_idx", 32'(obs_last_idx), 32'd1, run_len);

        for (int t = 0; t < 30; t++) begin
            nb  = int'($urandom_range(1, 4));
            gap = int'($urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0) begin
                cnt = 0;
                ab  = int'($urandom_range(1, 2));
            end else begin
                ab  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2));
                cnt = (ab == 0) ? nb : nb + int'($urandom_range(0, 2));
            end
            build_run(nb, gap, 0, 1, ab, 1);
            exec_run(8'($urandom), 3'($urandom), 8'($urandom), cnt, gap);
        end

        // Asynchronous reset in the middle of a run window
        @(negedge aclk);
        cfg_div_i = 8'h10; cfg_rep_i = 3'd3; cfg_order_i = 8'd7;
        burst_cnt_i = CW'(1); gap_len_i = '0;
        abort_i = 0; tx_flag_i = 0; start_i = 1;
        @(negedge aclk);
        start_i = 0;
        repeat (12) @(negedge aclk);
        check("pre_areset_en", 32'(dac_en_o), 32'd1, 13);
        #2 aresetn = 1'b0;
        #1;
        check("areset_dac_en", 32'(dac_en_o), 32'd0, 13);
        check("areset_tx_cfg", tx_cfg_o, 32'h0008_0000, 13);
        check("areset_busy", 32'(busy_o), 32'd0, 13);
        check("areset_done", 32'(done_o), 32'd0, 13);
        check("areset_idx", 32'(burst_idx_o), 32'd0, 13);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tx_burst_sequencer.md
Name: tx_burst_sequencer

Overview:
Sequences the LFSR-modulated DAC transmit path. Latches a burst configuration, drives the 32-bit TX configuration word (LFSR divider, repetition, order, sync reset) and the DAC enable gate, then runs N bursts separated by programmable idle gaps. Each burst ends on the LFSR completion flag. The block sits between the AXI-lite register bank and the DAC core, in the DAC `aclk` domain.

Parameters:
RST_CYCLES, 4, cycles the LFSR sync reset (cfg bit 19) is held before each burst; must be ≥1
SETTLE_CYCLES, 2, cycles between reset release and DAC enable; 0 is allowed
CNT_WIDTH, 16, width of the burst counter and burst index
GAP_WIDTH, 32, width of the inter-burst gap counter

Ports:
aclk  in  1  DAC/system clock
aresetn  in  1  asynchronous active-low reset
start_i  in  1  single-cycle start request; ignored unless IDLE
abort_i  in  1  level; forces return to IDLE
cfg_div_i  in  8  LFSR clock divider
cfg_rep_i  in  3  LFSR repetition count
cfg_order_i  in  8  LFSR order
burst_cnt_i  in  CNT_WIDTH  bursts per run; 0 = continuous until abort
gap_len_i  in  GAP_WIDTH  idle cycles between bursts
tx_flag_i  in  1  LFSR completion flag from the DAC core
tx_cfg_o  out  32  {12'b0, srst[19], order[18:11], rep[10:8], div[7:0]}
dac_en_o  out  1  gates DAC stream valid; DAC outputs zero when low
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse when a finite run completes
burst_idx_o  out  CNT_WIDTH  index of the current or last burst, 0-based

Behaviour:
- Reset values (async, aresetn=0):
  - state=IDLE
  - tx_cfg_o = 32'h0008_0000 (srst=1, other fields 0)
  - dac_en_o=0, busy_o=0, done_o=0, burst_idx_o=0
  - flag edge register = 0
- All outputs are registered.
- Config latch: start_i in IDLE latches div/rep/order/burst_cnt/gap_len. Input changes during a run have no effect.
- States:
  - IDLE:
    - srst=1, dac_en_o=0.
    - start_i → RST; burst_idx_o←0, counter←RST_CYCLES-1.
  - RST:
    - srst=1, latched fields driven onto tx_cfg_o.
    - Count down; at 0 → SETTLE, or → RUN if SETTLE_CYCLES=0.
  - SETTLE:
    - srst=0, dac_en_o=0.
    - Count SETTLE_CYCLES, then → RUN.
  - RUN:
    - srst=0, dac_en_o=1.
    - Wait for a rising edge of tx_flag_i (registered once; edge = flag & ~flag_q). A flag already high on RUN entry is not an edge.
    - On edge: if burst_cnt≠0 and burst_idx_o==burst_cnt-1 → DONE; else → GAP with counter←gap_len.
  - GAP:
    - dac_en_o=0, srst=1.
    - Count down gap_len cycles; gap_len=0 means zero gap cycles.
    - At expiry: burst_idx_o increments (wraps modulo 2^CNT_WIDTH in continuous mode), → RST.
  - DONE:
    - done_o=1 for exactly one cycle, dac_en_o=0, srst=1.
    - → IDLE next cycle.
- dac_en_o falls in the cycle after the terminating flag edge is sampled.
- abort_i has priority over every transition, including a simultaneous start_i or flag edge:
  - next state IDLE, dac_en_o=0 next cycle, srst=1.
  - No done_o pulse; burst_idx_o holds its value.
- start_i while busy_o=1 is ignored.
- Asynchronous reset mid-run returns all outputs to reset values immediately.
- burst_cnt_i=1 gives a single burst with no GAP state.
- Latency: start_i at cycle 0 → dac_en_o=1 at cycle 1+RST_CYCLES+SETTLE_CYCLES.

Decomposition:
- Shared package tx_seq_pkg holds:
  - state enum {IDLE, RST, SETTLE, RUN, GAP, DONE}
  - cfg bit-position constants: DIV_LSB=0, REP_LSB=8, ORDER_LSB=11, SRST_BIT=19
  - the tx_cfg field pack function
- One natural sub-module: seq_down_counter, a loadable down-counter with zero flag, shared by RST, SETTLE and GAP timing.
- The FSM and edge detector stay in the top module.

Test Plan:
- Reset: assert aresetn=0 mid-RUN → same cycle dac_en_o=0, tx_cfg_o=32'h0008_0000, busy_o=0.
- Single burst (RST_CYCLES=4, SETTLE_CYCLES=2), div=8'h10, rep=3, order=8'd7, burst_cnt=1, start at cycle 0:
  - tx_cfg_o=32'h0008_3B10 during RST.
  - dac_en_o=1 at cycle 7.
  - Flag edge at cycle 50 → dac_en_o=0 at cycle 51, done_o pulse at cycle 51.
- Three bursts, gap_len=10:
  - Three RUN windows, each gap exactly 10 cycles of dac_en_o=0 plus RST+SETTLE.
  - burst_idx_o steps 0→1→2, one done_o pulse.
- Continuous mode (burst_cnt=0): run 5 bursts, then abort_i → IDLE next cycle, no done_o, burst_idx_o=4.
- Flag already high on RUN entry: no burst termination until flag drops and rises again.
- Same-cycle abort_i and flag edge in the final burst: state→IDLE, done_o stays 0. start_i pulsed during RUN has no effect.
